// File: rtl/nand_rr_arbiter.sv
// Four-channel round-robin arbiter; the granted channel's A/B operands feed a registered NAND.
// Define NRR_HOLD_LIMIT_EN to cap each ownership at HOLD_MAX consecutive grant cycles.
module nand_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic [3:0] REQ,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] GNT,
    output logic       Y,
    output logic       VALID
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_e;

    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
        $error("nand_rr_arbiter: HOLD_MAX must be in 1..15");
    end

    state_e            state_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   owner_q;
    logic [CH_W-1:0]   pick_c;
    logic [CH_W-1:0]   idx_c;
    logic              found_c;
    logic              hold_hit_c;
    logic              release_c;

    // Rotating priority search: first requester at or above ptr_q, wrapping 3->0.
    always_comb begin
        pick_c  = ptr_q;
        idx_c   = ptr_q;
        found_c = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            idx_c = ptr_q + CH_W'(i);
            if (!found_c && REQ[idx_c]) begin
                pick_c  = idx_c;
                found_c = 1'b1;
            end
        end
    end

`ifdef NRR_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_q;

    assign hold_hit_c = (hold_q == CNT_W'(HOLD_MAX));

    // Counts grant cycles of the current ownership, starting at 1 on entry.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            hold_q <= '0;
        end else if (state_q == S_IDLE) begin
            hold_q <= found_c ? CNT_W'(1) : '0;
        end else if (release_c) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + CNT_W'(1);
        end
    end
`else
    assign hold_hit_c = 1'b0;
`endif

    assign release_c = !REQ[owner_q] || hold_hit_c;

    // Grant FSM with registered NAND result; an owner release always passes through IDLE.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            GNT     <= '0;
            Y       <= 1'b1;
            VALID   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_c) begin
                        state_q <= S_OWN;
                        owner_q <= pick_c;
                        GNT     <= N_CH'(1) << pick_c;
                    end
                end
                S_OWN: begin
                    Y     <= ~(A[owner_q] & B[owner_q]);
                    VALID <= 1'b1;
                    if (release_c) begin
                        state_q <= S_IDLE;
                        GNT     <= '0;
                        ptr_q   <= owner_q + CH_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    GNT     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_rr_arbiter.sv
// Self-checking bench for nand_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against an integer-level reference model.
module tb_nand_rr_arbiter;

    localparam int unsigned HOLD_MAX = 4;
`ifdef NRR_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR_N;
    logic [3:0] REQ;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] GNT;
    logic       Y;
    logic       VALID;

    int tests = 0;
    int fails = 0;

    // Reference model state: owner -1 means nobody holds the grant.
    int   m_owner;
    int   m_ptr;
    int   m_cnt;
    logic m_y;
    logic m_valid;

    nand_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .REQ   (REQ),
        .A     (A),
        .B     (B),
        .GNT   (GNT),
        .Y     (Y),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_y     = 1'b1;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
        if (m_owner < 0) begin
            m_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_cnt   = 1;
                end
            end
        end else begin
            m_y     = ~(a[m_owner] & b[m_owner]);
            m_valid = 1'b1;
            if (!r[m_owner] || (HOLD_EN && m_cnt == int'(HOLD_MAX))) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [3:0] m_gnt();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".gnt"}, GNT, m_gnt());
        chk({tag, ".y"}, {3'b000, Y}, {3'b000, m_y});
        chk({tag, ".valid"}, {3'b000, VALID}, {3'b000, m_valid});
        chk({tag, ".onehot"}, {3'b000, ($countones(GNT) <= 1)}, 4'b0001);
    endtask

    // Drive at the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        REQ = r;
        A   = a;
        B   = b;
        @(posedge CLK);
        model_edge(r, a, b);
        #1;
        check_model(tag);
    endtask

    // Reset pulse that starts and ends between two rising edges.
    task automatic mid_reset(input string tag);
        @(negedge CLK);
        #2;
        CLR_N = 1'b0;
        REQ   = 4'b0000;
        #1;
        chk({tag, ".gnt"}, GNT, 4'b0000);
        chk({tag, ".y"}, {3'b000, Y}, 4'b0001);
        chk({tag, ".valid"}, {3'b000, VALID}, 4'b0000);
        #1;
        CLR_N = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] order[$];
        logic [3:0] exp_order [5];
        int         own_cycles;
        int         lead_ch0;
        logic       lead_run;

        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;

        CLR_N = 1'b0;
        REQ   = 4'b0000;
        A     = 4'b0000;
        B     = 4'b0000;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset.gnt", GNT, 4'b0000);
        chk("reset.y", {3'b000, Y}, 4'b0001);
        chk("reset.valid", {3'b000, VALID}, 4'b0000);
        @(negedge CLK);
        CLR_N = 1'b1;

        // First grant and one-cycle NAND latency.
        step("first_grant", 4'b0100, 4'b0100, 4'b0100);
        chk("first_grant.lit", GNT, 4'b0100);
        step("first_y", 4'b0100, 4'b0100, 4'b0100);
        chk("first_y.lit", {3'b000, Y}, 4'b0000);
        chk("first_valid.lit", {3'b000, VALID}, 4'b0001);
        step("rel2", 4'b0000, 4'b0000, 4'b0000);

        // Wrap-around from pointer 3, then skip to channel 3 from pointer 1.
        step("wrap", 4'b0001, 4'b0000, 4'b0000);
        chk("wrap.lit", GNT, 4'b0001);
        step("rel0", 4'b0000, 4'b0000, 4'b0000);
        step("skip", 4'b1001, 4'b0000, 4'b0000);
        chk("skip.lit", GNT, 4'b1000);
        step("rel3", 4'b0000, 4'b0000, 4'b0000);

        // All requesting; each owner drops its request after two grant cycles.
        own_cycles = 0;
        for (int s = 0; s < 15; s++) begin
            r = 4'b1111;
            if (m_owner >= 0 && own_cycles >= 2) r[m_owner] = 1'b0;
            step("rr", r, 4'(s), 4'(s * 3));
            if (m_owner >= 0) begin
                own_cycles++;
                if (own_cycles == 1) order.push_back(GNT);
            end else begin
                own_cycles = 0;
            end
        end
        chk("rr.count", 4'(order.size()), 4'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("rr.order", order[i], exp_order[i]);

        // Steady two-channel request: hold limit decides whether channel 0 lets go.
        mid_reset("rst_idle");
        lead_ch0 = 0;
        lead_run = 1'b1;
        for (int s = 0; s < 12; s++) begin
            step("hold", 4'b0011, 4'(s), 4'b1111);
            if (lead_run && GNT == 4'b0001) lead_ch0++;
            else lead_run = 1'b0;
        end
        chk("hold.lead", 4'(lead_ch0), HOLD_EN ? 4'(HOLD_MAX) : 4'd12);

        // Asynchronous reset mid-grant, then a fresh search from channel 0.
        mid_reset("rst_mid");
        step("post_rst", 4'b0110, 4'b0010, 4'b0000);
        chk("post_rst.lit", GNT, 4'b0010);

        // Non-granted operand activity must not leak into Y.
        for (int s = 0; s < 3; s++) begin
            r = (s % 2 == 0) ? 4'b1010 : 4'b0010;
            step("isolate", 4'b0010, {r[3], 3'b010}, {r[3], 3'b000});
            chk("isolate.y", {3'b000, Y}, 4'b0001);
        end
        step("iso_rel", 4'b0000, 4'b1010, 4'b1000);
        step("iso_idle", 4'b0000, 4'b1111, 4'b1111);
        chk("iso_idle.y", {3'b000, Y}, 4'b0001);
        chk("iso_idle.valid", {3'b000, VALID}, 4'b0000);

        // Random traffic against the model.
        for (int s = 0; s < 300; s++) begin
            step("rand", 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
